iomem_gpio_bank: RTL

//   Parametrised GPIO peripheral on the picosoc iomem bus. Successor to the single
//   32-bit gpio register: adds per-bit direction, atomic set/clear/toggle,

---
 rtl/iomem_gpio_bank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/iomem_gpio_bank.sv
// iomem_gpio_bank: GPIO peripheral on the picosoc iomem bus.
//   Per-bit direction, atomic set/clear/toggle on the output register,
//   synchronised input readback, and edge-triggered interrupts with
//   per-bit enable, polarity and write-1-to-clear pending bits.
//
// Ports
//   clk, resetn          system clock, synchronous active-low reset
//   iomem_valid/ready    request / one-cycle acknowledge
//   iomem_wstrb          byte write strobes (0 = read)
//   iomem_addr/wdata     byte address, write data
//   iomem_rdata          read data, valid while iomem_ready=1, held otherwise
//   gpio_in              asynchronous pin inputs
//   gpio_out, gpio_oe    OUT and DIR registers
//   irq                  |(PEND & IRQ_EN)
//
// Register map (word index addr[5:2]):
//   0 OUT  1 SET  2 CLR  3 TGL  4 DIR  5 IN  6 IRQ_EN  7 IRQ_POL  8 PEND(W1C)
//   9..15 read 0, writes ignored.

// Per-bit input path: synchroniser, previous-value flop, edge detect, pending.
module iomem_gpio_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    input  logic pol,     // 1 = rising edge, 0 = falling edge
    input  logic w1c,     // clear request from a PEND write
    output logic in_s,
    output logic pend
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_det;

    assign in_s     = sync_q[SYNC_STAGES-1];
    assign edge_det = pol ? (in_s & ~prev_q) : (~in_s & prev_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= in_s;
            // A new edge takes priority over a simultaneous clear.
            pend   <= edge_det | (pend & ~w1c);
        end
    end
endmodule

module iomem_gpio_bank #(
    parameter logic [7:0]       BASE_HI     = 8'h03,
    parameter int               WIDTH       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    typedef enum logic [3:0] {
        R_OUT  = 4'd0, R_SET = 4'd1, R_CLR = 4'd2, R_TGL = 4'd3,
        R_DIR  = 4'd4, R_IN  = 4'd5, R_EN  = 4'd6, R_POL = 4'd7,
        R_PEND = 4'd8
    } reg_idx_e;

    logic [WIDTH-1:0] out_q, dir_q, en_q, pol_q;
    logic [WIDTH-1:0] in_s, pend, w1c;
    logic [WIDTH-1:0] wmask, d;
    logic [31:0]      lane_mask32, d32, rd_val;
    logic [WIDTH-1:0] rd_w;
    logic [3:0]       idx;
    logic             sel, wr;

    assign idx = iomem_addr[5:2];
    assign sel = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_HI);
    assign wr  = sel && (iomem_wstrb != 4'b0);

    // Byte strobes expanded to bit lanes; bits above WIDTH are dropped here.
    assign lane_mask32 = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                          {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign d32   = iomem_wdata & lane_mask32;
    assign wmask = lane_mask32[WIDTH-1:0];
    assign d     = d32[WIDTH-1:0];

    assign w1c = (wr && idx == R_PEND) ? d : '0;

    logic unused_bits;
    assign unused_bits = &{1'b0, iomem_addr[23:6], iomem_addr[1:0], d32, lane_mask32};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            iomem_gpio_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
                .clk    (clk),
                .resetn (resetn),
                .pin    (gpio_in[gi]),
                .pol    (pol_q[gi]),
                .w1c    (w1c[gi]),
                .in_s   (in_s[gi]),
                .pend   (pend[gi])
            );
        end
    endgenerate

    always_comb begin
        rd_w = '0;
        case (idx)
            R_OUT, R_SET, R_CLR, R_TGL: rd_w = out_q;
            R_DIR:  rd_w = dir_q;
            R_IN:   rd_w = in_s;
            R_EN:   rd_w = en_q;
            R_POL:  rd_w = pol_q;
            R_PEND: rd_w = pend;
            default: rd_w = '0;
        endcase
        rd_val = '0;
        rd_val[WIDTH-1:0] = rd_w;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            out_q       <= RESET_OUT;
            dir_q       <= RESET_DIR;
            en_q        <= '0;
            pol_q       <= '1;
        end else begin
            // ready is a single-cycle pulse; sel excludes the ack cycle.
            iomem_ready <= sel;
            if (sel) iomem_rdata <= rd_val;
            if (wr) begin
                case (idx)
                    R_OUT: out_q <= (out_q & ~wmask) | d;
                    R_SET: out_q <= out_q | d;
                    R_CLR: out_q <= out_q & ~d;
                    R_TGL: out_q <= out_q ^ d;
                    R_DIR: dir_q <= (dir_q & ~wmask) | d;
                    R_EN:  en_q  <= (en_q  & ~wmask) | d;
                    R_POL: pol_q <= (pol_q & ~wmask) | d;
                    default: ;
                endcase
            end
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = |(pend & en_q);
endmodule
